// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the byte producer, the TX FIFO and the serial transmitter.
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic                  ovf_clr;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  tx_busy;

  modport master (
    output wr_en, wr_data, ovf_clr, tx_busy,
    input  full, empty, level, overflow, tx_start, tx_data
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr, tx_busy,
    output full, empty, level, overflow, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a start/busy handshake.
// Define UART_TXFIFO_CRLF_EN to expand every 0x0A write into the pair 0x0D,0x0A.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus
);
  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                r_state;
  logic                  r_tx_start;
  logic [7:0]            r_tx_data;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_overflow;

  logic [7:0]            w_mem [DEPTH];
  logic [7:0]            w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_wr0;
  logic [7:0]            w_data0;
  logic                  w_drop;
  logic [DEPTH_LOG2:0]   w_inc;
  logic [DEPTH_LOG2:0]   w_dec;

  assign w_full  = (r_level == DEPTH_LVL);
  assign w_empty = (r_level == '0);
  assign w_pop   = (r_state == IDLE) && !w_empty && !bus.tx_busy;
  assign w_head  = w_mem[r_rd_ptr];

`ifdef UART_TXFIFO_CRLF_EN
  logic                  w_is_lf;
  logic                  w_room;
  logic                  w_wr1;
  logic [DEPTH_LOG2-1:0] w_wr_ptr1;

  // A line feed needs two free slots up front; the pop in the same cycle does not count.
  assign w_is_lf   = (bus.wr_data == 8'h0A);
  assign w_room    = w_is_lf ? (r_level <= (DEPTH_LVL - (DEPTH_LOG2+1)'(2))) : !w_full;
  assign w_wr0     = bus.wr_en && w_room;
  assign w_wr1     = w_wr0 && w_is_lf;
  assign w_data0   = w_is_lf ? 8'h0D : bus.wr_data;
  assign w_wr_ptr1 = r_wr_ptr + DEPTH_LOG2'(1);
  assign w_inc     = w_wr1 ? (DEPTH_LOG2+1)'(2) : (DEPTH_LOG2+1)'(w_wr0);
`else
  assign w_wr0   = bus.wr_en && !w_full;
  assign w_data0 = bus.wr_data;
  assign w_inc   = (DEPTH_LOG2+1)'(w_wr0);
`endif

  assign w_drop = bus.wr_en && !w_wr0;
  assign w_dec  = (DEPTH_LOG2+1)'(w_pop);

  // Storage entries are deliberately left out of reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [7:0] r_entry;
      logic       w_sel0;
      assign w_sel0 = w_wr0 && (r_wr_ptr == DEPTH_LOG2'(gi));
`ifdef UART_TXFIFO_CRLF_EN
      logic       w_sel1;
      assign w_sel1 = w_wr1 && (w_wr_ptr1 == DEPTH_LOG2'(gi));
      always_ff @(posedge clk) begin
        if (w_sel0) begin
          r_entry <= w_data0;
        end else if (w_sel1) begin
          r_entry <= 8'h0A;
        end
      end
`else
      always_ff @(posedge clk) begin
        if (w_sel0) begin
          r_entry <= w_data0;
        end
      end
`endif
      assign w_mem[gi] = r_entry;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_inc[DEPTH_LOG2-1:0];
      r_level  <= r_level + w_inc - w_dec;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_data  <= w_head;
            r_tx_start <= 1'b1;
            r_state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.level    = r_level;
  assign bus.overflow = r_overflow;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter (busy 10 cycles, 1 cycle after start).
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH_LOG2(4)) bus ();

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         starts = 0;
  int         viol   = 0;
  logic [7:0] q_out[$];
  logic       tx_hold;
  logic       m_busy;
  int         m_cnt;
  logic       prev_start;

  assign bus.tx_busy = tx_hold | m_busy;

  // Transmitter model plus start-pulse protocol monitor.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy     <= 1'b0;
      m_cnt      <= 0;
      prev_start <= 1'b0;
    end else begin
      prev_start <= bus.tx_start;
      if (bus.tx_start) begin
        q_out.push_back(bus.tx_data);
        starts <= starts + 1;
        $display("tx byte 0x%02h at %0t", bus.tx_data, $time);
        if (prev_start || bus.tx_busy) viol <= viol + 1;
        m_busy <= 1'b1;
        m_cnt  <= 10;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_busy <= 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.ovf_clr = 1'b0;
    tx_hold = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", bus.full); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", bus.empty); end
    checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.level); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", bus.overflow); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %0b want 0", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %02h want 00", bus.tx_data); end
    rst_n = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_single();
    int base_s;
    base_s = starts;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_data = 8'h55;
    @(negedge clk);
    bus.wr_en = 1'b0;
    checks++; if (bus.level !== 5'd1) begin errors++; $display("FAIL single_level_after_write got %0d want 1", bus.level); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL single_early_start got %0b want 0", bus.tx_start); end
    @(negedge clk);
    checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("FAIL single_start_latency got %0b want 1", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h55) begin errors++; $display("FAIL single_tx_data got %02h want 55", bus.tx_data); end
    checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL single_level_after_pop got %0d want 0", bus.level); end
    @(negedge clk);
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %0b want 0", bus.tx_start); end
    repeat (20) @(negedge clk);
    checks++; if (starts - base_s !== 1) begin errors++; $display("FAIL single_start_count got %0d want 1", starts - base_s); end
    checks++; if (bus.tx_data !== 8'h55) begin errors++; $display("FAIL single_tx_data_hold got %02h want 55", bus.tx_data); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_empty got %0b want 1", bus.empty); end
  endtask

  task automatic test_full_overflow();
    @(negedge clk);
    tx_hold = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_flag got %0b want 1", bus.full); end
    checks++; if (bus.level !== 5'd16) begin errors++; $display("FAIL full_level got %0d want 16", bus.level); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_no_overflow_yet got %0b want 0", bus.overflow); end
    bus.wr_en = 1'b1; bus.wr_data = 8'hAA;
    @(negedge clk);
    bus.wr_en = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", bus.overflow); end
    checks++; if (bus.level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", bus.level); end
  endtask

  task automatic test_ovf_clr();
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr_alone got %0b want 0", bus.overflow); end
    bus.ovf_clr = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hBB;
    @(negedge clk);
    bus.ovf_clr = 1'b0; bus.wr_en = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %0b want 1", bus.overflow); end
    checks++; if (bus.level !== 5'd16) begin errors++; $display("FAIL ovf_clr_level got %0d want 16", bus.level); end
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr_next got %0b want 0", bus.overflow); end
  endtask

  task automatic test_drain_order();
    int base_q;
    base_q = q_out.size();
    tx_hold = 1'b0;
    for (int k = 0; k < 400 && (q_out.size() - base_q) < 16; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++; if (q_out.size() - base_q !== 16) begin errors++; $display("FAIL drain_count got %0d want 16", q_out.size() - base_q); end
    for (int i = 0; i < 16; i++) begin
      if (base_q + i < q_out.size()) begin
        checks++; if (q_out[base_q+i] !== 8'(i)) begin errors++; $display("FAIL drain_order[%0d] got %02h want %02h", i, q_out[base_q+i], 8'(i)); end
      end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %0b want 1", bus.empty); end
  endtask

  task automatic test_wrap();
    int base_q;
    base_q = q_out.size();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_data = 8'(i * 5 + 3);
      @(negedge clk);
      bus.wr_en = 1'b0;
      repeat (12) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    checks++; if (q_out.size() - base_q !== 40) begin errors++; $display("FAIL wrap_count got %0d want 40", q_out.size() - base_q); end
    for (int i = 0; i < 40; i++) begin
      if (base_q + i < q_out.size()) begin
        checks++; if (q_out[base_q+i] !== 8'(i * 5 + 3)) begin errors++; $display("FAIL wrap_order[%0d] got %02h want %02h", i, q_out[base_q+i], 8'(i * 5 + 3)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int base_s;
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_data = vals[i];
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    checks++; if (bus.level !== 5'd3) begin errors++; $display("FAIL rstmid_level_before got %0d want 3", bus.level); end
    checks++; if (bus.tx_data !== 8'h11) begin errors++; $display("FAIL rstmid_tx_data_before got %02h want 11", bus.tx_data); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL rstmid_level got %0d want 0", bus.level); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %0b want 1", bus.empty); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data got %02h want 00", bus.tx_data); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL rstmid_tx_start got %0b want 0", bus.tx_start); end
    @(negedge clk);
    rst_n = 1'b1;
    base_s = starts;
    repeat (40) @(negedge clk);
    checks++; if (starts - base_s !== 0) begin errors++; $display("FAIL rstmid_no_start got %0d want 0", starts - base_s); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty_after got %0b want 1", bus.empty); end
  endtask

`ifdef UART_TXFIFO_CRLF_EN
  task automatic test_crlf();
    int base_q;
    base_q = q_out.size();
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_data = 8'h41;
    @(negedge clk);
    bus.wr_data = 8'h0A;
    @(negedge clk);
    bus.wr_en = 1'b0;
    for (int k = 0; k < 200 && (q_out.size() - base_q) < 3; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++; if (q_out.size() - base_q !== 3) begin errors++; $display("FAIL crlf_count got %0d want 3", q_out.size() - base_q); end
    if (q_out.size() - base_q >= 3) begin
      checks++; if (q_out[base_q] !== 8'h41) begin errors++; $display("FAIL crlf_byte0 got %02h want 41", q_out[base_q]); end
      checks++; if (q_out[base_q+1] !== 8'h0D) begin errors++; $display("FAIL crlf_byte1 got %02h want 0d", q_out[base_q+1]); end
      checks++; if (q_out[base_q+2] !== 8'h0A) begin errors++; $display("FAIL crlf_byte2 got %02h want 0a", q_out[base_q+2]); end
    end
    @(negedge clk);
    tx_hold = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h60 + i);
    end
    @(negedge clk);
    checks++; if (bus.level !== 5'd15) begin errors++; $display("FAIL crlf_fill_level got %0d want 15", bus.level); end
    bus.wr_data = 8'h0A;
    @(negedge clk);
    bus.wr_en = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL crlf_drop_overflow got %0b want 1", bus.overflow); end
    checks++; if (bus.level !== 5'd15) begin errors++; $display("FAIL crlf_drop_level got %0d want 15", bus.level); end
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    base_q = q_out.size();
    tx_hold = 1'b0;
    for (int k = 0; k < 400 && (q_out.size() - base_q) < 15; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++; if (q_out.size() - base_q !== 15) begin errors++; $display("FAIL crlf_drain_count got %0d want 15", q_out.size() - base_q); end
  endtask
`else
  task automatic test_lf_verbatim();
    int base_q;
    base_q = q_out.size();
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_data = 8'h0A;
    @(negedge clk);
    bus.wr_en = 1'b0;
    checks++; if (bus.level !== 5'd1) begin errors++; $display("FAIL lf_level got %0d want 1", bus.level); end
    repeat (30) @(negedge clk);
    checks++; if (q_out.size() - base_q !== 1) begin errors++; $display("FAIL lf_count got %0d want 1", q_out.size() - base_q); end
    if (q_out.size() - base_q >= 1) begin
      checks++; if (q_out[base_q] !== 8'h0A) begin errors++; $display("FAIL lf_byte got %02h want 0a", q_out[base_q]); end
    end
  endtask
`endif

  task automatic test_protocol();
    checks++; if (viol !== 0) begin errors++; $display("FAIL protocol_start_rule got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_overflow();
    test_ovf_clr();
    test_drain_order();
    test_wrap();
    test_reset_mid();
`ifdef UART_TXFIFO_CRLF_EN
    test_crlf();
`else
    test_lf_verbatim();
`endif
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
